arc4_encrypt: RTL and testbench

- ARC4 encryptor; the producer/writer side of the ciphertext memory that the cracking blocks read.
- Reads a length-prefixed plaintext from pt memory and runs the ARC4 KSA and PRGA using an external 256x8 S memory.
- Writes the length-prefixed ciphertext into ct memory (same format, byte 0 = length), so the result is directly consumable by the crack/decrypt blocks.
- Generates encrypted test images for crack benches.

---
 rtl/arc4_encrypt.sv | 209 ++++++++++++++++++++
 tb/tb_arc4_encrypt.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/arc4_encrypt.sv
// ARC4 encryptor: reads a length-prefixed plaintext, runs KSA + PRGA over an
// external 256x8 S memory and writes the length-prefixed ciphertext.
module arc4_encrypt (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    output logic        rdy,
    input  logic [23:0] key,
    output logic [7:0]  s_addr,
    output logic [7:0]  s_wrdata,
    output logic        s_wren,
    input  logic [7:0]  s_rddata,
    output logic [7:0]  pt_addr,
    input  logic [7:0]  pt_rddata,
    output logic [7:0]  ct_addr,
    output logic [7:0]  ct_wrdata,
    output logic        ct_wren
);

    typedef enum logic [3:0] {
        IDLE,
        INIT,
        KSA_RI,
        KSA_RJ,
        KSA_WI,
        KSA_WJ,
        LEN_RD,
        LEN_WR,
        PRGA_RI,
        PRGA_RJ,
        PRGA_WI,
        PRGA_WJ,
        PRGA_PAD,
        PRGA_OUT,
        DONE
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  i_q, i_d;
    logic [7:0]  j_q, j_d;
    logic [7:0]  k_q, k_d;
    logic [7:0]  len_q, len_d;
    logic [7:0]  si_q, si_d;
    logic [7:0]  sj_q, sj_d;
    logic [23:0] key_q, key_d;
    logic [1:0]  kidx_q, kidx_d;

    logic [7:0]  key_byte;
    logic [7:0]  j_sum;

    // kidx tracks i mod 3 so no divider is needed for the key schedule
    always_comb begin
        case (kidx_q)
            2'd0:    key_byte = key_q[23:16];
            2'd1:    key_byte = key_q[15:8];
            default: key_byte = key_q[7:0];
        endcase
    end

    always_comb begin
        state_d   = state_q;
        i_d       = i_q;
        j_d       = j_q;
        k_d       = k_q;
        len_d     = len_q;
        si_d      = si_q;
        sj_d      = sj_q;
        key_d     = key_q;
        kidx_d    = kidx_q;
        j_sum     = 8'd0;
        rdy       = 1'b0;
        s_addr    = 8'd0;
        s_wrdata  = 8'd0;
        s_wren    = 1'b0;
        pt_addr   = 8'd0;
        ct_addr   = 8'd0;
        ct_wrdata = 8'd0;
        ct_wren   = 1'b0;

        case (state_q)
            IDLE: begin
                rdy = 1'b1;
                if (en) begin
                    key_d   = key;
                    i_d     = 8'd0;
                    state_d = INIT;
                end
            end
            INIT: begin
                s_addr   = i_q;
                s_wrdata = i_q;
                s_wren   = 1'b1;
                i_d      = i_q + 8'd1;
                if (i_q == 8'd255) begin
                    j_d     = 8'd0;
                    kidx_d  = 2'd0;
                    state_d = KSA_RI;
                end
            end
            KSA_RI: begin
                s_addr  = i_q;
                state_d = KSA_RJ;
            end
            KSA_RJ: begin
                j_sum   = j_q + s_rddata + key_byte;
                s_addr  = j_sum;
                j_d     = j_sum;
                si_d    = s_rddata;
                state_d = KSA_WI;
            end
            // Reads of S[j] always complete before either swap write is issued
            KSA_WI: begin
                s_addr   = i_q;
                s_wrdata = s_rddata;
                s_wren   = 1'b1;
                state_d  = KSA_WJ;
            end
            KSA_WJ: begin
                s_addr   = j_q;
                s_wrdata = si_q;
                s_wren   = 1'b1;
                i_d      = i_q + 8'd1;
                kidx_d   = (kidx_q == 2'd2) ? 2'd0 : kidx_q + 2'd1;
                state_d  = (i_q == 8'd255) ? LEN_RD : KSA_RI;
            end
            LEN_RD: begin
                state_d = LEN_WR;
            end
            LEN_WR: begin
                len_d     = pt_rddata;
                ct_wrdata = pt_rddata;
                ct_wren   = 1'b1;
                i_d       = 8'd0;
                j_d       = 8'd0;
                k_d       = 8'd1;
                state_d   = (pt_rddata == 8'd0) ? DONE : PRGA_RI;
            end
            PRGA_RI: begin
                s_addr  = i_q + 8'd1;
                i_d     = i_q + 8'd1;
                state_d = PRGA_RJ;
            end
            PRGA_RJ: begin
                j_sum   = j_q + s_rddata;
                s_addr  = j_sum;
                j_d     = j_sum;
                si_d    = s_rddata;
                state_d = PRGA_WI;
            end
            PRGA_WI: begin
                sj_d     = s_rddata;
                s_addr   = i_q;
                s_wrdata = s_rddata;
                s_wren   = 1'b1;
                state_d  = PRGA_WJ;
            end
            PRGA_WJ: begin
                s_addr   = j_q;
                s_wrdata = si_q;
                s_wren   = 1'b1;
                state_d  = PRGA_PAD;
            end
            // The swap does not change S[i]+S[j], so the pre-swap values index the pad
            PRGA_PAD: begin
                s_addr  = si_q + sj_q;
                pt_addr = k_q;
                state_d = PRGA_OUT;
            end
            PRGA_OUT: begin
                ct_addr   = k_q;
                ct_wrdata = s_rddata ^ pt_rddata;
                ct_wren   = 1'b1;
                k_d       = k_q + 8'd1;
                state_d   = (k_q == len_q) ? DONE : PRGA_RI;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            i_q     <= 8'd0;
            j_q     <= 8'd0;
            k_q     <= 8'd0;
            len_q   <= 8'd0;
            si_q    <= 8'd0;
            sj_q    <= 8'd0;
            key_q   <= 24'd0;
            kidx_q  <= 2'd0;
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            j_q     <= j_d;
            k_q     <= k_d;
            len_q   <= len_d;
            si_q    <= si_d;
            sj_q    <= sj_d;
            key_q   <= key_d;
            kidx_q  <= kidx_d;
        end
    end

endmodule

// File: tb/tb_arc4_encrypt.sv
// Bench for arc4_encrypt: memory models, ARC4 software model feeding a
// scoreboard of expected ct writes, vector table plus reset/round-trip cases.
`timescale 1ns/1ps
module tb_arc4_encrypt;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        rdy;
    logic [23:0] key;
    logic [7:0]  s_addr, s_wrdata, s_rddata;
    logic        s_wren;
    logic [7:0]  pt_addr, pt_rddata;
    logic [7:0]  ct_addr, ct_wrdata;
    logic        ct_wren;

    always #5 clk = ~clk;

    arc4_encrypt dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .rdy       (rdy),
        .key       (key),
        .s_addr    (s_addr),
        .s_wrdata  (s_wrdata),
        .s_wren    (s_wren),
        .s_rddata  (s_rddata),
        .pt_addr   (pt_addr),
        .pt_rddata (pt_rddata),
        .ct_addr   (ct_addr),
        .ct_wrdata (ct_wrdata),
        .ct_wren   (ct_wren)
    );

    logic [7:0] s_mem  [256];
    logic [7:0] pt_mem [256];
    logic [7:0] ct_mem [256];

    always @(posedge clk) begin
        s_rddata  <= s_mem[s_addr];
        pt_rddata <= pt_mem[pt_addr];
        if (s_wren)  s_mem[s_addr]  <= s_wrdata;
        if (ct_wren) ct_mem[ct_addr] <= ct_wrdata;
    end

    int n_checks = 0;
    int n_pass   = 0;
    int wr_count = 0;
    logic [15:0] exp_q [$];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    // Scoreboard: every ct write must match the next expected {addr,data}
    always @(negedge clk) begin
        if (!rst && ct_wren) begin
            wr_count++;
            if (exp_q.size() == 0) begin
                check("unexpected_ct_write", {16'd0, ct_addr, ct_wrdata}, 32'hFFFFFFFF);
            end else begin
                check("ct_write", {16'd0, ct_addr, ct_wrdata}, {16'd0, exp_q.pop_front()});
            end
        end
    end

    task automatic push_model(input logic [23:0] k);
        logic [7:0] s [256];
        logic [7:0] kb [3];
        logic [7:0] i, j, t, len;
        kb[0] = k[23:16];
        kb[1] = k[15:8];
        kb[2] = k[7:0];
        for (int n = 0; n < 256; n++) s[n] = n[7:0];
        j = 8'd0;
        for (int n = 0; n < 256; n++) begin
            j = j + s[n] + kb[n % 3];
            t = s[n]; s[n] = s[j]; s[j] = t;
        end
        len = pt_mem[0];
        exp_q.push_back({8'd0, len});
        i = 8'd0;
        j = 8'd0;
        for (int n = 1; n <= int'(len); n++) begin
            i = i + 8'd1;
            j = j + s[i];
            t = s[i]; s[i] = s[j]; s[j] = t;
            t = s[i] + s[j];
            exp_q.push_back({n[7:0], s[t] ^ pt_mem[n]});
        end
    endtask

    task automatic run_enc(input logic [23:0] k, input bit pulse, input int exp_writes, input string tag);
        int cyc;
        int lim;
        lim = 256 + 256 * 6 + 4 + 8 * int'(pt_mem[0]);
        push_model(k);
        wr_count = 0;
        @(negedge clk);
        check({tag, "_rdy_idle"}, {31'd0, rdy}, 32'd1);
        key = k;
        en  = 1'b1;
        @(posedge clk);
        #1;
        en  = 1'b0;
        key = ~k;
        cyc = 1;
        while (rdy !== 1'b1 && cyc < 4000) begin
            @(posedge clk);
            #1;
            cyc++;
            if (pulse) en = (cyc == 5 || cyc == 100 || cyc == 2000);
        end
        en = 1'b0;
        check({tag, "_done"}, {31'd0, rdy}, 32'd1);
        check({tag, "_latency_ok"}, {31'd0, (cyc <= lim)}, 32'd1);
        @(negedge clk);
        check({tag, "_pending"}, exp_q.size(), 32'd0);
        check({tag, "_nwrites"}, wr_count, exp_writes);
        exp_q.delete();
        $display("run %s key=%06h len=%0d cycles=%0d writes=%0d", tag, k, pt_mem[0], cyc, wr_count);
    endtask

    task automatic fill_std();
        string msg;
        msg = "Plaintext";
        pt_mem[0] = 8'd9;
        for (int n = 0; n < 9; n++) pt_mem[n + 1] = msg[n];
    endtask

    task automatic fill_rand(input int len);
        for (int n = 0; n < 256; n++) pt_mem[n] = 8'($urandom_range(0, 255));
        pt_mem[0] = len[7:0];
    endtask

    typedef struct {
        logic [23:0] key;
        int          len;
        int          mode;        // 0 standard text, 1 random fill, 2 keep current pt
        bit          pulse;
        int          exp_writes;
    } vec_t;

    vec_t       vecs [5];
    logic [7:0] std_ct [9];
    logic [7:0] ref_ct [256];
    logic [7:0] orig   [51];

    initial begin
        vecs[0] = '{24'h4B6579,   9, 0, 1'b0,  10};
        vecs[1] = '{24'h000000,   0, 1, 1'b0,   1};
        vecs[2] = '{24'hFFFFFF, 255, 1, 1'b0, 256};
        vecs[3] = '{24'hFFFFFF, 255, 2, 1'b1, 256};
        vecs[4] = '{24'h1E4600,  50, 1, 1'b0,  51};
        std_ct  = '{8'hBB, 8'hF3, 8'h16, 8'hE8, 8'hD9, 8'h40, 8'hAF, 8'h0A, 8'hD3};

        rst = 1'b1;
        en  = 1'b0;
        key = 24'd0;
        #1;
        check("rst_rdy", {31'd0, rdy}, 32'd1);
        check("rst_s_wren", {31'd0, s_wren}, 32'd0);
        check("rst_ct_wren", {31'd0, ct_wren}, 32'd0);
        check("rst_addrs", {8'd0, s_addr, pt_addr, ct_addr}, 32'd0);
        check("rst_data", {16'd0, s_wrdata, ct_wrdata}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        for (int v = 0; v < 5; v++) begin
            case (vecs[v].mode)
                0:       fill_std();
                1:       fill_rand(vecs[v].len);
                default: ;
            endcase
            run_enc(vecs[v].key, vecs[v].pulse, vecs[v].exp_writes, $sformatf("vec%0d", v));
            if (v == 0) begin
                check("std_len", {24'd0, ct_mem[0]}, 32'd9);
                for (int n = 0; n < 9; n++)
                    check($sformatf("std_ct%0d", n + 1), {24'd0, ct_mem[n + 1]}, {24'd0, std_ct[n]});
            end
            if (v == 2) for (int n = 0; n < 256; n++) ref_ct[n] = ct_mem[n];
            if (v == 3) begin
                for (int n = 0; n < 256; n++)
                    if (ct_mem[n] !== ref_ct[n])
                        check($sformatf("pulse_same_ct%0d", n), {24'd0, ct_mem[n]}, {24'd0, ref_ct[n]});
                check("pulse_same_ct0", {24'd0, ct_mem[0]}, {24'd0, ref_ct[0]});
            end
        end

        // Round trip: re-encrypting the ciphertext recovers the plaintext
        for (int n = 0; n <= 50; n++) begin
            orig[n]   = pt_mem[n];
            pt_mem[n] = ct_mem[n];
        end
        run_enc(24'h1E4600, 1'b0, 51, "roundtrip");
        for (int n = 0; n <= 50; n++)
            if (ct_mem[n] !== orig[n])
                check($sformatf("rt_byte%0d", n), {24'd0, ct_mem[n]}, {24'd0, orig[n]});
        check("rt_len", {24'd0, ct_mem[0]}, 32'h32);

        // Asynchronous reset in the middle of KSA, then a clean standard run
        fill_std();
        @(negedge clk);
        key = 24'h4B6579;
        en  = 1'b1;
        @(posedge clk);
        #1;
        en = 1'b0;
        repeat (799) @(posedge clk);
        #2;
        check("busy_before_rst", {31'd0, rdy}, 32'd0);
        rst = 1'b1;
        #1;
        check("async_rst_rdy", {31'd0, rdy}, 32'd1);
        check("async_rst_wren", {30'd0, s_wren, ct_wren}, 32'd0);
        check("async_rst_saddr", {24'd0, s_addr}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        run_enc(24'h4B6579, 1'b0, 10, "after_rst");
        for (int n = 0; n < 9; n++)
            check($sformatf("rst_std_ct%0d", n + 1), {24'd0, ct_mem[n + 1]}, {24'd0, std_ct[n]});

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
